instr_mem_loader: RTL and testbench

Write-side counterpart to the instruction-memory read path. The block receives a byte stream, for example from a UART receiver or a testbench driver, over a valid/ready handshake. It assembles the bytes MSB-first into 32-bit MIPS instruction words and writes them into consecutive word indices of the instruction memory. Read-side addressing uses the word index as `program_counter`, so the first word loaded lands at index 0.

---
 rtl/instr_mem_loader.sv | 117 +++++++++++
 tb/tb_instr_mem_loader.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: packs an MSB-first byte stream into 32-bit words written to consecutive instruction-memory indices.
// Define LOADER_CHECKSUM_EN to consume a trailing XOR checksum byte and flag mismatches on err_o.
module instr_mem_loader #(
    parameter int DEPTH = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [31:0] num_words_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_data_i,
    output logic        byte_ready_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] word_count_o,
    output logic        err_o
);
    typedef enum logic [2:0] {
        IDLE,
        RECV,
        WRITE,
`ifdef LOADER_CHECKSUM_EN
        CHECK,
`endif
        DONE
    } state_t;

    state_t      state_q;
    logic [31:0] target_q, count_q, addr_q, wdata_q, word_q;
    logic [1:0]  idx_q;
    logic        accept;
    logic [31:0] word_d, count_d, target_d;

    assign accept   = byte_valid_i && byte_ready_o;
    assign word_d   = {word_q[23:0], byte_data_i};
    assign count_d  = count_q + 32'd1;
    assign target_d = (num_words_i > 32'(DEPTH)) ? 32'(DEPTH) : num_words_i;

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] xor_q;
    logic       err_q;
    assign byte_ready_o = (state_q == RECV) || (state_q == CHECK);
    assign err_o        = err_q;
`else
    assign byte_ready_o = (state_q == RECV);
    assign err_o        = 1'b0;
`endif
    assign mem_we_o     = (state_q == WRITE);
    assign busy_o       = (state_q != IDLE);
    assign done_o       = (state_q == DONE);
    assign mem_addr_o   = addr_q;
    assign mem_wdata_o  = wdata_q;
    assign word_count_o = count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            target_q <= '0;
            count_q  <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            word_q   <= '0;
            idx_q    <= '0;
`ifdef LOADER_CHECKSUM_EN
            xor_q    <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: if (start_i) begin
                    target_q <= target_d;
                    count_q  <= '0;
                    addr_q   <= '0;
                    idx_q    <= '0;
`ifdef LOADER_CHECKSUM_EN
                    xor_q    <= '0;
                    err_q    <= 1'b0;
`endif
                    state_q  <= (target_d == 32'd0) ? DONE : RECV;
                end
                RECV: if (accept) begin
                    word_q <= word_d;
                    idx_q  <= idx_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                    xor_q  <= xor_q ^ byte_data_i;
`endif
                    // Address and data are latched here so they hold steady outside WRITE.
                    if (idx_q == 2'd3) begin
                        addr_q  <= count_q;
                        wdata_q <= word_d;
                        state_q <= WRITE;
                    end
                end
                WRITE: begin
                    count_q <= count_d;
                    idx_q   <= '0;
`ifdef LOADER_CHECKSUM_EN
                    state_q <= (count_d == target_q) ? CHECK : RECV;
`else
                    state_q <= (count_d == target_q) ? DONE : RECV;
`endif
                end
`ifdef LOADER_CHECKSUM_EN
                CHECK: if (accept) begin
                    err_q   <= (byte_data_i != xor_q);
                    state_q <= DONE;
                end
`endif
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: directed checks of word assembly, clamping, zero-length loads, ignored start and mid-load reset.
module tb_instr_mem_loader;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] num_words = '0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = '0;
    logic        byte_ready, mem_we, busy, done, err;
    logic [31:0] mem_addr, mem_wdata, word_count;
    int          checks = 0;
    int          failures = 0;
    int          done_n = 0;
    logic [7:0]  xr = '0;
    logic [31:0] wa[$];
    logic [31:0] wd[$];

    instr_mem_loader #(.DEPTH(64)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .num_words_i(num_words),
        .byte_valid_i(byte_valid), .byte_data_i(byte_data), .byte_ready_o(byte_ready),
        .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .busy_o(busy), .done_o(done), .word_count_o(word_count), .err_o(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) begin
            wa.push_back(mem_addr);
            wd.push_back(mem_wdata);
        end
        if (done) done_n++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input bit gap);
        int n = 0;
        if (gap) repeat ($urandom_range(0, 2)) step();
        byte_valid = 1'b1;
        byte_data  = b;
        while (!byte_ready && n < 20) begin
            step();
            n++;
        end
        if (!byte_ready) chk("ready_timeout", {31'b0, byte_ready}, 32'd1);
        step();
        byte_valid = 1'b0;
        xr ^= b;
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap);
        for (int k = 0; k < 4; k++) send(w[31-8*k -: 8], gap);
    endtask

    task automatic start_load(input logic [31:0] n);
        wa.delete();
        wd.delete();
        done_n    = 0;
        xr        = '0;
        start     = 1'b1;
        num_words = n;
        step();
        start     = 1'b0;
    endtask

    task automatic end_load();
`ifdef LOADER_CHECKSUM_EN
        send(xr, 1'b0);
`else
        step();
`endif
    endtask

    task automatic prog3(input bit gap);
        logic [31:0] exp[3] = '{32'h20080005, 32'h2009000A, 32'h01095020};
        start_load(3);
        chk("busy_after_start", {31'b0, busy}, 32'd1);
        for (int i = 0; i < 3; i++) send_word(exp[i], gap);
        end_load();
        chk("prog3_done", {31'b0, done}, 32'd1);
        chk("prog3_count", word_count, 32'd3);
        step();
        chk("prog3_done_fall", {31'b0, done}, 32'd0);
        chk("prog3_busy_fall", {31'b0, busy}, 32'd0);
        chk("prog3_nwrites", wa.size(), 32'd3);
        for (int i = 0; i < 3 && i < wa.size(); i++) begin
            chk("prog3_addr", wa[i], i);
            chk("prog3_data", wd[i], exp[i]);
        end
        chk("prog3_done_pulses", done_n, 32'd1);
    endtask

    initial begin
        #1;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_ready", {31'b0, byte_ready}, 32'd0);
        chk("rst_we", {31'b0, mem_we}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_count", word_count, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // Write strobe timing on the first word, then the full three-word program.
        start_load(3);
        send_word(32'h20080005, 1'b0);
        chk("w0_we", {31'b0, mem_we}, 32'd1);
        chk("w0_addr", mem_addr, 32'd0);
        chk("w0_wdata", mem_wdata, 32'h20080005);
        chk("w0_ready_low", {31'b0, byte_ready}, 32'd0);
        send_word(32'h2009000A, 1'b0);
        send_word(32'h01095020, 1'b0);
        end_load();
        step();
        chk("first_idle", {31'b0, busy}, 32'd0);

        prog3(1'b0);
        prog3(1'b1);

        // Clamp to DEPTH.
        start_load(100);
        for (int i = 0; i < 64; i++) send_word({8'(i), 8'(i + 1), 8'hA5, 8'(~i)}, 1'b0);
        end_load();
        chk("clamp_done", {31'b0, done}, 32'd1);
        chk("clamp_count", word_count, 32'd64);
        chk("clamp_nwrites", wa.size(), 32'd64);
        if (wa.size() > 0) begin
            chk("clamp_last_addr", wa[wa.size()-1], 32'd63);
            chk("clamp_last_data", wd[wd.size()-1], 32'h3F40A5C0);
        end
        step();
        byte_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("clamp_ready_stays_low", {31'b0, byte_ready}, 32'd0);
            step();
        end
        byte_valid = 1'b0;
        chk("clamp_addr_hold", mem_addr, 32'd63);

        // Zero-length load.
        start_load(0);
        chk("zero_done", {31'b0, done}, 32'd1);
        chk("zero_busy", {31'b0, busy}, 32'd1);
        step();
        chk("zero_done_fall", {31'b0, done}, 32'd0);
        chk("zero_busy_fall", {31'b0, busy}, 32'd0);
        chk("zero_nwrites", wa.size(), 32'd0);

        // start while busy is ignored.
        start_load(2);
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b0);
        start = 1'b1;
        num_words = 5;
        step();
        start = 1'b0;
        chk("ign_busy", {31'b0, busy}, 32'd1);
        chk("ign_ready", {31'b0, byte_ready}, 32'd1);
        send(8'hCC, 1'b0);
        send(8'hDD, 1'b0);
        send_word(32'h01234567, 1'b0);
        end_load();
        chk("ign_done", {31'b0, done}, 32'd1);
        chk("ign_count", word_count, 32'd2);
        step();
        chk("ign_nwrites", wa.size(), 32'd2);
        if (wd.size() == 2) begin
            chk("ign_w0", wd[0], 32'hAABBCCDD);
            chk("ign_w1", wd[1], 32'h01234567);
            chk("ign_a1", wa[1], 32'd1);
        end

        // Asynchronous reset after six bytes.
        start_load(3);
        send_word(32'hDEADBEEF, 1'b0);
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'b0, busy}, 32'd0);
        chk("arst_ready", {31'b0, byte_ready}, 32'd0);
        chk("arst_addr", mem_addr, 32'd0);
        chk("arst_wdata", mem_wdata, 32'd0);
        chk("arst_count", word_count, 32'd0);
        chk("arst_nwrites", wa.size(), 32'd1);
        step();
        rst_n = 1'b1;
        step();
        start_load(1);
        send_word(32'hCAFEF00D, 1'b0);
        end_load();
        step();
        chk("arst_reload_n", wa.size(), 32'd1);
        if (wa.size() == 1) begin
            chk("arst_reload_addr", wa[0], 32'd0);
            chk("arst_reload_data", wd[0], 32'hCAFEF00D);
        end

`ifdef LOADER_CHECKSUM_EN
        start_load(2);
        send_word(32'h12345678, 1'b0);
        send_word(32'h00000000, 1'b0);
        send(8'h08, 1'b0);
        chk("cs_good_done", {31'b0, done}, 32'd1);
        chk("cs_good_err", {31'b0, err}, 32'd0);
        step();
        start_load(2);
        send_word(32'h12345678, 1'b0);
        send_word(32'h00000000, 1'b0);
        send(8'h09, 1'b0);
        chk("cs_bad_err", {31'b0, err}, 32'd1);
        repeat (3) step();
        chk("cs_bad_sticky", {31'b0, err}, 32'd1);
        start_load(0);
        chk("cs_err_cleared", {31'b0, err}, 32'd0);
        step();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
